// File: rtl/sdram_axi_pkg.sv
// Shared constants, state encoding and LFSR step function for the SDRAM AXI tester.
package sdram_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WA,
    ST_WD,
    ST_WB,
    ST_RA,
    ST_RD,
    ST_FIN
  } state_t;

  // Galois LFSR, shifting right and applying the taps when the bit shifted out is 1
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/sdram_axi_tester_if.sv
// AXI4 channel bundle between the tester (master) and the SDRAM controller slave port.
interface sdram_axi_tester_if;
  import sdram_axi_pkg::*;

  logic                  awvalid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_ID_W-1:0]   awid;
  logic [AXI_LEN_W-1:0]  awlen;
  logic [1:0]            awburst;
  logic                  awready;

  logic                  wvalid;
  logic [AXI_DATA_W-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wready;

  logic                  bvalid;
  logic [1:0]            bresp;
  logic [AXI_ID_W-1:0]   bid;
  logic                  bready;

  logic                  arvalid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_LEN_W-1:0]  arlen;
  logic [1:0]            arburst;
  logic                  arready;

  logic                  rvalid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic [AXI_ID_W-1:0]   rid;
  logic                  rlast;
  logic                  rready;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arburst, input arready,
    input rvalid, rdata, rresp, rid, rlast, output rready
  );

  modport slave (
    input awvalid, awaddr, awid, awlen, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input arvalid, araddr, arid, arlen, arburst, output arready,
    output rvalid, rdata, rresp, rid, rlast, input rready
  );
endinterface

// File: rtl/sdram_lfsr32.sv
// 32-bit Galois LFSR pattern source; load takes priority over step.
module sdram_lfsr32
  import sdram_axi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] value_o
);

  logic [31:0] value_q;

  // Reload with the seed at phase boundaries, otherwise advance once per accepted beat
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    value_q <= '0;
    else if (load_i) value_q <= seed_i;
    else if (step_i) value_q <= lfsr_next(value_q);
  end

  assign value_o = value_q;

endmodule

// File: rtl/sdram_axi_tester.sv
// AXI4 write/readback pattern tester: writes LFSR bursts, reads them back, counts errors.
module sdram_axi_tester
  import sdram_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          NUM_BURSTS = 16,
  parameter int          BURST_LEN  = 8,
  parameter logic [31:0] SEED       = 32'hACE1_0001
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  sdram_axi_tester_if.master axi_m
);

  localparam logic [15:0] LAST_IDX  = 16'(NUM_BURSTS - 1);
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [31:0] STRIDE    = 32'(BURST_LEN * 4);

  state_t      state_q;
  logic [15:0] idx_q;
  logic [7:0]  beat_q;
  logic [31:0] burst_addr_q;
  logic        awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic        busy_q, done_q, pass_q;
  logic [15:0] err_cnt_q;
  logic [31:0] first_err_q;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        last_burst, last_beat;
  logic        lfsr_load, lfsr_step;
  logic [31:0] lfsr_value;
  logic        beat_err;
  logic [31:0] err_addr;

  assign aw_hs      = awvalid_q & axi_m.awready;
  assign w_hs       = wvalid_q  & axi_m.wready;
  assign b_hs       = bready_q  & axi_m.bvalid;
  assign ar_hs      = arvalid_q & axi_m.arready;
  assign r_hs       = rready_q  & axi_m.rvalid;
  assign last_burst = (idx_q == LAST_IDX);
  assign last_beat  = (beat_q == LAST_BEAT);

  // LFSR control: seed at pass start and again before the readback phase
  always_comb begin
    lfsr_load = ((state_q == ST_IDLE) & start_i) | ((state_q == ST_WB) & b_hs & last_burst);
    lfsr_step = ((state_q == ST_WD) & w_hs) | ((state_q == ST_RD) & r_hs);
  end

  // Error detection for the response or beat accepted this cycle; several causes count once
  always_comb begin
    beat_err = 1'b0;
    err_addr = burst_addr_q;
    if (state_q == ST_WB) begin
      beat_err = b_hs & ((axi_m.bresp != AXI_RESP_OKAY) | (axi_m.bid != '0));
    end else if (state_q == ST_RD) begin
      beat_err = r_hs & ((axi_m.rdata != lfsr_value) | (axi_m.rresp != AXI_RESP_OKAY) |
                         (axi_m.rid != '0) | (axi_m.rlast != last_beat));
      err_addr = burst_addr_q + {22'd0, beat_q, 2'b00};
    end
  end

  sdram_lfsr32 u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (lfsr_load),
    .seed_i  (SEED),
    .step_i  (lfsr_step),
    .value_o (lfsr_value)
  );

  // Main sequencer: one AXI transaction outstanding at a time, all handshake outputs registered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      beat_q       <= '0;
      burst_addr_q <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
    end else begin
      if (beat_err) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0)    first_err_q <= err_addr;
      end
      case (state_q)
        ST_IDLE: if (start_i) begin
          err_cnt_q    <= '0;
          first_err_q  <= '0;
          done_q       <= 1'b0;
          pass_q       <= 1'b0;
          busy_q       <= 1'b1;
          idx_q        <= '0;
          beat_q       <= '0;
          burst_addr_q <= ADDR_BASE;
          awvalid_q    <= 1'b1;
          state_q      <= ST_WA;
        end
        ST_WA: if (aw_hs) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          wlast_q   <= (LAST_BEAT == 8'd0);
          beat_q    <= '0;
          state_q   <= ST_WD;
        end
        ST_WD: if (w_hs) begin
          if (last_beat) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= ST_WB;
          end else begin
            beat_q  <= beat_q + 8'd1;
            wlast_q <= (beat_q == LAST_BEAT - 8'd1);
          end
        end
        ST_WB: if (b_hs) begin
          bready_q <= 1'b0;
          if (last_burst) begin
            idx_q        <= '0;
            burst_addr_q <= ADDR_BASE;
            arvalid_q    <= 1'b1;
            state_q      <= ST_RA;
          end else begin
            idx_q        <= idx_q + 16'd1;
            burst_addr_q <= burst_addr_q + STRIDE;
            awvalid_q    <= 1'b1;
            state_q      <= ST_WA;
          end
        end
        ST_RA: if (ar_hs) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          beat_q    <= '0;
          state_q   <= ST_RD;
        end
        ST_RD: if (r_hs) begin
          // A burst ends on rlast or on the final expected beat, whichever comes first
          if (axi_m.rlast | last_beat) begin
            rready_q <= 1'b0;
            if (last_burst) begin
              state_q <= ST_FIN;
            end else begin
              idx_q        <= idx_q + 16'd1;
              burst_addr_q <= burst_addr_q + STRIDE;
              arvalid_q    <= 1'b1;
              state_q      <= ST_RA;
            end
          end else begin
            beat_q <= beat_q + 8'd1;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_cnt_q == 16'd0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi_m.awvalid = awvalid_q;
  assign axi_m.awaddr  = burst_addr_q;
  assign axi_m.awid    = '0;
  assign axi_m.awlen   = LAST_BEAT;
  assign axi_m.awburst = AXI_BURST_INCR;
  assign axi_m.wvalid  = wvalid_q;
  assign axi_m.wdata   = lfsr_value;
  assign axi_m.wstrb   = 4'hF;
  assign axi_m.wlast   = wlast_q;
  assign axi_m.bready  = bready_q;
  assign axi_m.arvalid = arvalid_q;
  assign axi_m.araddr  = burst_addr_q;
  assign axi_m.arid    = '0;
  assign axi_m.arlen   = LAST_BEAT;
  assign axi_m.arburst = AXI_BURST_INCR;
  assign axi_m.rready  = rready_q;

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_sdram_axi_tester.sv
// Directed bench: reactive AXI slave with memory, table-driven pass scenarios, plus
// hand-written restart and asynchronous-reset sequences.
module tb_sdram_axi_tester;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int NB = 2;
  localparam int BL = 4;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err;

  sdram_axi_tester_if axi_if ();

  sdram_axi_tester #(
    .ADDR_BASE (BASE),
    .NUM_BURSTS(NB),
    .BURST_LEN (BL),
    .SEED      (SEED)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_count_o     (err_count),
    .first_err_addr_o(first_err),
    .axi_m           (axi_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder configuration
  bit cfg_bp = 0;
  int cfg_corrupt_burst = -1, cfg_corrupt_beat = -1;
  int cfg_bresp_burst = -1;
  int cfg_early_burst = -1, cfg_early_beat = -1;

  // Responder state and logs
  logic [31:0] mem [0:63];
  logic [31:0] w_log[$];
  logic [31:0] aw_log[$];
  int          ar_cnt = 0, b_cnt = 0, rd_beats = 0, stall_viol = 0;
  int          w_beat = 0, r_beat = 0, r_burst = 0;
  logic [31:0] w_base, r_addr, tmp_a;
  bit          b_pend, r_active, b_fire, r_fire, ar_fire, wl_fire;
  bit          aw_stall, w_stall, ar_stall;
  logic [31:0] aw_hold, w_hold, ar_hold;
  logic        wl_hold;

  // Slave model: retire transfers of the last edge, choose new outputs, then note
  // which transfers the coming edge will accept
  always @(negedge clk) begin
    if (!rst_n) begin
      axi_if.awready = 0; axi_if.wready = 0; axi_if.arready = 0;
      axi_if.bvalid = 0; axi_if.bresp = 0; axi_if.bid = 0;
      axi_if.rvalid = 0; axi_if.rdata = 0; axi_if.rresp = 0; axi_if.rid = 0; axi_if.rlast = 0;
      b_pend = 0; r_active = 0; b_fire = 0; r_fire = 0; ar_fire = 0; wl_fire = 0;
      aw_stall = 0; w_stall = 0; ar_stall = 0;
    end else begin
      if (b_fire) axi_if.bvalid = 0;
      if (r_fire) begin
        axi_if.rvalid = 0;
        if (axi_if.rlast) r_active = 0;
        else r_beat++;
      end
      if (ar_fire) begin r_active = 1; r_beat = 0; end
      if (wl_fire) b_pend = 1;
      if (aw_stall && !(axi_if.awvalid && axi_if.awaddr == aw_hold)) stall_viol++;
      if (w_stall && !(axi_if.wvalid && axi_if.wdata == w_hold && axi_if.wlast == wl_hold)) stall_viol++;
      if (ar_stall && !(axi_if.arvalid && axi_if.araddr == ar_hold)) stall_viol++;
      axi_if.awready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_if.wready  = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_if.arready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_pend && !axi_if.bvalid) begin
        axi_if.bvalid = 1;
        axi_if.bresp  = (b_cnt == cfg_bresp_burst) ? 2'b10 : 2'b00;
        b_cnt++;
        b_pend = 0;
      end
      if (r_active && !axi_if.rvalid && (!cfg_bp || $urandom_range(0, 1) == 1)) begin
        tmp_a = r_addr + 32'(r_beat * 4);
        axi_if.rvalid = 1;
        axi_if.rdata  = mem[tmp_a[7:2]] ^
                        ((r_burst == cfg_corrupt_burst && r_beat == cfg_corrupt_beat) ? 32'd1 : 32'd0);
        axi_if.rlast  = (r_beat == BL - 1) || (r_burst == cfg_early_burst && r_beat == cfg_early_beat);
      end
      if (axi_if.awvalid && axi_if.awready) begin
        aw_log.push_back(axi_if.awaddr);
        w_base = axi_if.awaddr;
        w_beat = 0;
      end
      wl_fire = 0;
      if (axi_if.wvalid && axi_if.wready) begin
        tmp_a = w_base + 32'(w_beat * 4);
        mem[tmp_a[7:2]] = axi_if.wdata;
        w_log.push_back(axi_if.wdata);
        w_beat++;
        wl_fire = axi_if.wlast;
      end
      b_fire  = axi_if.bvalid && axi_if.bready;
      r_fire  = axi_if.rvalid && axi_if.rready;
      if (r_fire) rd_beats++;
      ar_fire = axi_if.arvalid && axi_if.arready;
      if (ar_fire) begin r_addr = axi_if.araddr; r_burst = ar_cnt; ar_cnt++; end
      aw_stall = axi_if.awvalid && !axi_if.awready; aw_hold = axi_if.awaddr;
      w_stall  = axi_if.wvalid && !axi_if.wready;   w_hold = axi_if.wdata; wl_hold = axi_if.wlast;
      ar_stall = axi_if.arvalid && !axi_if.arready; ar_hold = axi_if.araddr;
    end
  end

  function automatic logic [31:0] ref_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic run_start();
    w_log.delete(); aw_log.delete();
    ar_cnt = 0; b_cnt = 0; rd_beats = 0; stall_viol = 0;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      tick();
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_writes(input string name);
    logic [31:0] v;
    int bad;
    v = SEED;
    bad = 0;
    for (int i = 0; i < NB * BL; i++) begin
      if (w_log[i] !== v) bad++;
      v = ref_next(v);
    end
    check({name, "_wbeats"}, 32'(w_log.size()), 32'(NB * BL));
    check({name, "_wdata_seq_bad"}, 32'(bad), 32'd0);
    check({name, "_wdata0"}, w_log[0], 32'hACE1_0001);
    check({name, "_wdata1"}, w_log[1], 32'hD650_8003);
    check({name, "_awaddr0"}, aw_log[0], 32'h0000_0100);
    check({name, "_awaddr1"}, aw_log[1], 32'h0000_0110);
  endtask

  typedef struct {
    string       name;
    bit          bp;
    int          corrupt_burst, corrupt_beat, bresp_burst, early_burst, early_beat;
    logic [15:0] exp_err;
    logic [31:0] exp_first;
    logic        exp_pass;
    int          exp_rbeats;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"ideal",       0, -1, -1, -1, -1, -1, 16'd0, 32'h0,     1'b1, 8};
    vecs[1] = '{"backpress",   1, -1, -1, -1, -1, -1, 16'd0, 32'h0,     1'b1, 8};
    vecs[2] = '{"rdata_bit0",  0,  1,  2, -1, -1, -1, 16'd1, 32'h118,   1'b0, 8};
    vecs[3] = '{"bresp_rlast", 0, -1, -1,  0,  1,  1, 16'd2, 32'h100,   1'b0, 6};

    rst_n = 0;
    start = 0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_first", first_err, 0);
    check("rst_awvalid", 32'(axi_if.awvalid), 0);
    check("rst_wvalid", 32'(axi_if.wvalid), 0);
    check("rst_arvalid", 32'(axi_if.arvalid), 0);
    check("rst_bready", 32'(axi_if.bready), 0);
    check("rst_rready", 32'(axi_if.rready), 0);
    check("rst_awburst", 32'(axi_if.awburst), 32'd1);
    check("rst_wstrb", 32'(axi_if.wstrb), 32'hF);
    check("rst_arid", 32'(axi_if.arid), 0);
    rst_n = 1;
    tick();

    for (int k = 0; k < 4; k++) begin
      cfg_bp = vecs[k].bp;
      cfg_corrupt_burst = vecs[k].corrupt_burst;
      cfg_corrupt_beat  = vecs[k].corrupt_beat;
      cfg_bresp_burst   = vecs[k].bresp_burst;
      cfg_early_burst   = vecs[k].early_burst;
      cfg_early_beat    = vecs[k].early_beat;
      run_start();
      wait_done(vecs[k].name);
      $display("vector %s: err=%0d first=%h pass=%0d rbeats=%0d",
               vecs[k].name, err_count, first_err, pass, rd_beats);
      check({vecs[k].name, "_pass"}, 32'(pass), 32'(vecs[k].exp_pass));
      check({vecs[k].name, "_err"}, 32'(err_count), 32'(vecs[k].exp_err));
      check({vecs[k].name, "_first"}, first_err, vecs[k].exp_first);
      check({vecs[k].name, "_busy"}, 32'(busy), 0);
      check({vecs[k].name, "_ar_cnt"}, 32'(ar_cnt), 32'(NB));
      check({vecs[k].name, "_rbeats"}, 32'(rd_beats), 32'(vecs[k].exp_rbeats));
      check({vecs[k].name, "_stall_viol"}, 32'(stall_viol), 0);
      check_writes(vecs[k].name);
    end

    // Restart after an erroring pass: status clears, and a start while busy is ignored
    cfg_bp = 0; cfg_corrupt_burst = -1; cfg_bresp_burst = -1; cfg_early_burst = -1;
    run_start();
    check("restart_done_clr", 32'(done), 0);
    check("restart_err_clr", 32'(err_count), 0);
    check("restart_first_clr", first_err, 0);
    check("restart_busy", 32'(busy), 1);
    repeat (5) tick();
    start = 1;
    tick();
    start = 0;
    wait_done("busy_start");
    $display("busy_start: err=%0d pass=%0d wbeats=%0d", err_count, pass, w_log.size());
    check("busy_start_pass", 32'(pass), 1);
    check("busy_start_wbeats", 32'(w_log.size()), 32'(NB * BL));
    check("busy_start_awcnt", 32'(aw_log.size()), 32'(NB));

    // Asynchronous reset in the middle of the second write burst
    cfg_bresp_burst = 0;
    run_start();
    for (int i = 0; i < 200; i++) begin
      if (axi_if.wvalid && aw_log.size() == 2) break;
      tick();
    end
    check("mid_wd_reached", 32'(axi_if.wvalid), 1);
    check("mid_wd_err", 32'(err_count), 1);
    #2 rst_n = 0;
    #1;
    $display("async reset: wvalid=%0d busy=%0d err=%0d", axi_if.wvalid, busy, err_count);
    check("arst_wvalid", 32'(axi_if.wvalid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_err", 32'(err_count), 0);
    repeat (2) tick();
    rst_n = 1;
    cfg_bresp_burst = -1;
    tick();
    run_start();
    wait_done("after_rst");
    $display("after_rst: err=%0d pass=%0d", err_count, pass);
    check("after_rst_pass", 32'(pass), 1);
    check("after_rst_err", 32'(err_count), 0);
    check_writes("after_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
